instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 144 ++++++++++++++
 tb/tb_instr_encoder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32 instruction-field packer with 2-entry output FIFO and delivery counters
module instr_encoder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [WIDTH-1:0] in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic             out_err,
  output logic [15:0]      enc_count,
  output logic [15:0]      err_count
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  // Representability: the bits above the field's sign bit must all copy it.
  logic fits_i;
  logic fits_b;
  logic fits_j;

  assign fits_i = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits_b = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits_j = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  logic [WIDTH-1:0] enc_instr;
  logic             enc_err;

  // Pack the fields by format; errored known formats still emit the truncated packing.
  always_comb begin
    enc_instr = '0;
    enc_err   = 1'b0;
    case (in_opcode)
      OP_IMM, OP_LOAD: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = ~fits_i;
      end
      OP_STORE: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err   = ~fits_i;
      end
      OP_BRANCH: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        enc_err   = in_imm[0] | ~fits_b;
      end
      OP_LUI, OP_AUIPC: begin
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
        enc_err   = |in_imm[11:0];
      end
      OP_JAL: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err   = in_imm[0] | ~fits_j;
      end
      OP_REG: begin
        enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = 1'b0;
      end
      default: begin
        enc_instr = '0;
        enc_err   = 1'b1;
      end
    endcase
  end

  // Two-slot ring buffer; the 1-bit pointers wrap naturally.
  logic [WIDTH-1:0] fifo_instr [2];
  logic             fifo_err   [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign in_ready  = (count != 2'd2) && !rst;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  // Reset discards pending words, so nothing is delivered in a reset cycle.
  assign pop       = out_valid && out_ready && !rst;

  assign out_instr = out_valid ? fifo_instr[rd_ptr] : '0;
  assign out_err   = out_valid ? fifo_err[rd_ptr]   : 1'b0;

  // FIFO storage, pointers and occupancy; push and pop in one cycle leave occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_instr[i] <= '0;
        fifo_err[i]   <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_instr[wr_ptr] <= enc_instr;
        fifo_err[wr_ptr]   <= enc_err;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Delivery counters, saturating so a long run never wraps back to small values.
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_count <= 16'd0;
      err_count <= 16'd0;
    end else if (pop) begin
      if (enc_count != COUNT_MAX) begin
        enc_count <= enc_count + 16'd1;
      end
      if (out_err && (err_count != COUNT_MAX)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder with random stimulus and reference model
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  instr_encoder #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [31:0] imm;
    logic        chk_imm;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int passes = 0;
  int model_enc = 0;
  int model_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_instr = '0;
  logic        prev_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
  endtask

  // Reference encoder built from range arithmetic and bit placement by shifts.
  function automatic logic [32:0] model(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] u);
    int s;
    logic [31:0] w;
    logic e;
    logic [31:0] base;
    s = $signed(u);
    base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    w = 0;
    e = 0;
    case (op)
      7'b0010011, 7'b0000011: begin
        e = (s < -2048) || (s > 2047);
        w = ((u & 32'hFFF) << 20) | base | (32'(rd) << 7);
      end
      7'b0100011: begin
        e = (s < -2048) || (s > 2047);
        w = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base | ((u & 32'h1F) << 7);
      end
      7'b1100011: begin
        e = ((u & 1) != 0) || (s < -4096) || (s > 4095);
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (32'(rs2) << 20) | base |
            (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7);
      end
      7'b0110111, 7'b0010111: begin
        e = (u % 4096) != 0;
        w = (u & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
      end
      7'b1101111: begin
        e = ((u & 1) != 0) || (s < -(1 << 20)) || (s >= (1 << 20));
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20) |
            (((u >> 12) & 255) << 12) | (32'(rd) << 7) | 32'(op);
      end
      7'b0110011: begin
        e = 0;
        w = (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
      end
      default: begin
        e = 1;
        w = 0;
      end
    endcase
    return {e, w};
  endfunction

  // Immediate generator: recover the sign-extended immediate from an encoded word.
  function automatic logic [31:0] decode_imm(input logic [31:0] w);
    case (w[6:0])
      7'b0010011, 7'b0000011: return {{20{w[31]}}, w[31:20]};
      7'b0100011:             return {{20{w[31]}}, w[31:25], w[11:7]};
      7'b1100011:             return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      7'b0110111, 7'b0010111: return {w[31:12], 12'b0};
      7'b1101111:             return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default:                return 32'h0;
    endcase
  endfunction

  function automatic logic imm_kind(input logic [6:0] op);
    case (op)
      7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b0110111, 7'b0010111, 7'b1101111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: compares every delivered word against the scoreboard head, plus counters and hold rules.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sbq.delete();
      model_enc = 0;
      model_err = 0;
      prev_stall = 1'b0;
      check("in_ready_during_rst", 32'(in_ready), 32'd0);
    end else begin
      check("enc_count", 32'(enc_count), 32'(model_enc));
      check("err_count", 32'(err_count), 32'(model_err));
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_instr", out_instr, prev_instr);
        check("hold_err", 32'(out_err), 32'(prev_err));
      end
      if (!out_valid) begin
        check("idle_instr", out_instr, 32'd0);
        check("idle_err", 32'(out_err), 32'd0);
      end else if (out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output: got %h err %b, expected no word", out_instr, out_err);
        end else begin
          e = sbq.pop_front();
          check("out_instr", out_instr, e.instr);
          check("out_err", 32'(out_err), 32'(e.err));
          if (e.chk_imm && !e.err) check("imm_roundtrip", decode_imm(out_instr), e.imm);
        end
        if (model_enc < 65535) model_enc++;
        if (out_err && model_err < 65535) model_err++;
      end
      prev_stall = out_valid && !out_ready;
      prev_instr = out_instr;
      prev_err   = out_err;
    end
  end

  // Present one request from posedge+1 until accepted; expectation enters the scoreboard on accept.
  task automatic issue(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                       input logic [31:0] ei, input logic ee);
    int waited = 0;
    exp_t e;
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    @(negedge clk);
    while (!in_ready && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL accept_timeout: in_ready %b, required 1 within 60 cycles", in_ready);
    end else begin
      e.instr = ei; e.err = ee; e.imm = imm; e.chk_imm = imm_kind(op);
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue_model(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                             input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    logic [32:0] m;
    m = model(op, rd, rs1, rs2, f3, f7, imm);
    issue(op, rd, rs1, rs2, f3, f7, imm, m[31:0], m[32]);
  endtask

  // Wait until the scoreboard empties, then one edge so counters reflect the last delivery.
  task automatic drain();
    int waited = 0;
    while (sbq.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (sbq.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", sbq.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [6:0] op_tab [8] = '{7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(in_ready), 32'd1);
    check("valid_after_reset", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Known encodings, including truncated packings for errored immediates.
    issue(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
    issue(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h80000093, 1'b1);
    issue(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h00000008, 32'h00208463, 1'b0);
    issue(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h00000003, 32'h00208163, 1'b1);
    issue(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h001000EF, 1'b0);
    issue(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
    issue(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h123452B7, 1'b1);
    issue(7'b0001111, 5'd3, 5'd4, 5'd5, 3'd1, 7'd0, 32'h00000010, 32'h00000000, 1'b1);
    drain();
    check("directed_enc_count", 32'(enc_count), 32'd8);
    check("directed_err_count", 32'(err_count), 32'd4);

    // Backpressure: two accepts fill the FIFO, the third waits for out_ready.
    pulse_reset();
    out_ready = 1'b0;
    issue_model(7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'h0);
    issue_model(7'b0010011, 5'd4, 5'd5, 5'd0, 3'd4, 7'd0, 32'h7FF);
    fork
      issue_model(7'b0100011, 5'd0, 5'd6, 5'd7, 3'd2, 7'd0, 32'hFFFFF800);
    join_none
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait fork;
    drain();
    check("bp_enc_count", 32'(enc_count), 32'd3);

    // Reset with two words pending discards them.
    out_ready = 1'b0;
    issue_model(7'b0010111, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000);
    issue_model(7'b1101111, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00000);
    pulse_reset();
    @(negedge clk);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_enc_count", 32'(enc_count), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Random traffic with random output backpressure.
    done = 0;
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          logic [6:0] op;
          logic [31:0] imm;
          int mode;
          op = op_tab[$urandom_range(0, 7)];
          if ($urandom_range(0, 9) == 0) begin
            op = 7'($urandom);
            if (imm_kind(op) || op == 7'b0110011) op = 7'b0001111;
          end
          mode = $urandom_range(0, 3);
          case (mode)
            0: imm = $urandom;
            1: imm = 32'($signed($urandom_range(0, 10000)) - 5000);
            2: imm = $urandom & 32'hFFFFF000;
            default: imm = 32'($signed($urandom_range(0, 4_000_000)) - 2_000_000) & ~32'h1;
          endcase
          issue_model(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm);
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
